adma_cm_irq_ctrl: RTL and testbench

Per-channel interrupt controller for the AXI DMA channel manager. It sits directly downstream of the per-descriptor transfer-status register. It watches each descriptor's done flag, latches masked completion events into a pending register, and drives one level interrupt per channel. On a software W1C it returns a one-cycle `xfer_done_clear` pulse to the status stage, which closes the done/clear loop for non-cyclic transfers.

---
 rtl/adma_cm_irq_ctrl_if.sv | 29 ++
 rtl/adma_cm_irq_ctrl.sv | 143 ++++++++++++++
 tb/tb_adma_cm_irq_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adma_cm_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// adma_cm_irq_ctrl_if : status/register-block side signals of the DMA
//                       channel interrupt controller.          Rev 1.0
// ============================================================================
interface adma_cm_irq_ctrl_if #(
    parameter int DMA_DESC_DEPTH = 4,
    parameter int COAL_CNT_W     = 8
);
    logic [DMA_DESC_DEPTH-1:0] xfer_done;
    logic [DMA_DESC_DEPTH-1:0] irq_en;
    logic [DMA_DESC_DEPTH-1:0] irq_clr;
    logic [COAL_CNT_W-1:0]     coal_thresh;
    logic [COAL_CNT_W-1:0]     coal_timeout;
    logic [DMA_DESC_DEPTH-1:0] irq_pending;
    logic [DMA_DESC_DEPTH-1:0] xfer_done_clear;
    logic                      irq;

    modport master (
        output xfer_done, irq_en, irq_clr, coal_thresh, coal_timeout,
        input  irq_pending, xfer_done_clear, irq
    );

    modport slave (
        input  xfer_done, irq_en, irq_clr, coal_thresh, coal_timeout,
        output irq_pending, xfer_done_clear, irq
    );
endinterface
`default_nettype wire

// File: rtl/adma_cm_irq_ctrl.sv
`default_nettype none
// ============================================================================
// adma_cm_irq_ctrl : per-channel DMA completion interrupt controller.
// Optional interrupt coalescing FSM enabled by defining ADMA_IRQ_COAL_EN.
// Rev 1.0
// ============================================================================
module adma_cm_irq_ctrl #(
    parameter int DMA_DESC_DEPTH = 4,
    parameter int COAL_CNT_W     = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    adma_cm_irq_ctrl_if.slave    bus
);

    logic [DMA_DESC_DEPTH-1:0] r_done_q;
    logic [DMA_DESC_DEPTH-1:0] r_evt;
    logic [DMA_DESC_DEPTH-1:0] r_pending;
    logic [DMA_DESC_DEPTH-1:0] r_clr_q;

    // Events are registered before they reach the pending bits so that every
    // output is a pure register and done-to-pending latency is two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q  <= '0;
            r_evt     <= '0;
            r_pending <= '0;
            r_clr_q   <= '0;
        end else begin
            r_done_q  <= bus.xfer_done;
            r_evt     <= bus.xfer_done & ~r_done_q & bus.irq_en;
            r_pending <= (r_pending & ~bus.irq_clr) | r_evt;
            r_clr_q   <= bus.irq_clr;
        end
    end

    assign bus.irq_pending     = r_pending;
    assign bus.xfer_done_clear = r_clr_q;

`ifdef ADMA_IRQ_COAL_EN
    localparam int         POP_W   = $clog2(DMA_DESC_DEPTH + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FIRE  = 2'd2;

    logic [1:0]            r_state, w_state_nxt;
    logic [COAL_CNT_W-1:0] r_evt_cnt, w_evt_cnt_nxt;
    logic [COAL_CNT_W-1:0] r_timer, w_timer_nxt;
    logic [COAL_CNT_W-1:0] w_thresh_eff;
    logic [COAL_CNT_W-1:0] w_evt_base;
    logic [COAL_CNT_W-1:0] w_evt_sat;
    logic [COAL_CNT_W:0]   w_evt_sum;
    logic [POP_W-1:0]      w_evt_pop;
    logic                  w_fire_hit;
    logic                  w_irq;

    always_comb begin
        w_evt_pop = '0;
        for (int i = 0; i < DMA_DESC_DEPTH; i++) begin
            w_evt_pop = w_evt_pop + POP_W'(r_evt[i]);
        end
    end

    // Accumulate only while in a live ACCUM; every other path loads fresh.
    assign w_evt_base   = (r_state == S_ACCUM && r_pending != '0) ? r_evt_cnt : '0;
    assign w_evt_sum    = {1'b0, w_evt_base} + (COAL_CNT_W+1)'(w_evt_pop);
    assign w_evt_sat    = w_evt_sum[COAL_CNT_W] ? '1 : w_evt_sum[COAL_CNT_W-1:0];
    assign w_thresh_eff = (bus.coal_thresh == '0) ? COAL_CNT_W'(1) : bus.coal_thresh;
    assign w_fire_hit   = (r_evt_cnt >= w_thresh_eff) ||
                          ((bus.coal_timeout != '0) && (r_timer == bus.coal_timeout));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_evt_cnt <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_evt_cnt <= w_evt_cnt_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_evt_cnt_nxt = r_evt_cnt;
        w_timer_nxt   = r_timer;
        case (r_state)
            S_IDLE: begin
                if (r_evt != '0) begin
                    w_state_nxt   = S_ACCUM;
                    w_evt_cnt_nxt = w_evt_sat;
                    w_timer_nxt   = '0;
                end
            end
            S_ACCUM, S_FIRE: begin
                // An event racing the final clear restarts accumulation
                // instead of leaving a pending bit stranded in IDLE.
                if (r_pending == '0) begin
                    w_state_nxt   = (r_evt != '0) ? S_ACCUM : S_IDLE;
                    w_evt_cnt_nxt = w_evt_sat;
                    w_timer_nxt   = '0;
                end else if (r_state == S_ACCUM) begin
                    if (w_fire_hit) begin
                        w_state_nxt = S_FIRE;
                    end else begin
                        w_evt_cnt_nxt = w_evt_sat;
                        w_timer_nxt   = (r_timer == '1) ? r_timer : r_timer + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_evt_cnt_nxt = '0;
                w_timer_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_irq = (r_state == S_FIRE);
    end

    assign bus.irq = w_irq;
`else
    logic r_irq;
    logic w_unused_coal;

    assign w_unused_coal = ^{bus.coal_thresh, bus.coal_timeout};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_pending;
        end
    end

    assign bus.irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adma_cm_irq_ctrl.sv
`default_nettype none
// Self-checking bench for adma_cm_irq_ctrl; coalescing scenarios run only
// when ADMA_IRQ_COAL_EN is defined, otherwise coal_thresh is held at 1.
module tb_adma_cm_irq_ctrl;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    typedef struct {
        logic [3:0] p;
        logic [3:0] c;
        logic       i;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t exp_q[$];

    adma_cm_irq_ctrl_if #(.DMA_DESC_DEPTH(DEPTH), .COAL_CNT_W(CW)) bus_if ();

    adma_cm_irq_ctrl #(.DMA_DESC_DEPTH(DEPTH), .COAL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        exp_t e;
        bus_if.xfer_done    = '0;
        bus_if.irq_en       = '0;
        bus_if.irq_clr      = '0;
        bus_if.coal_thresh  = 8'd1;
        bus_if.coal_timeout = 8'd0;
        #1 rst_n = 1'b0;
        exp_q.push_back('{4'h0, 4'h0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
            n_mis++;
            $display("FAIL reset: got p=%b c=%b irq=%b want p=%b c=%b irq=%b",
                     bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
        end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold_clear();
        logic [3:0] d[8], cl[8], ep[8], ec[8];
        logic       ei[8];
        exp_t       e;
        d  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
        cl = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
        ep = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
        ec = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
        ei = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bus_if.irq_en = 4'hF;
        for (int r = 0; r < 8; r++) begin
            bus_if.xfer_done = d[r];
            bus_if.irq_clr   = cl[r];
            exp_q.push_back('{ep[r], ec[r], ei[r]});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL hold_clear[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
    endtask

    task automatic test_mask();
        logic [3:0] d[4], cl[4], ec[4];
        exp_t       e;
        d  = '{4'h1, 4'h1, 4'h1, 4'h0};
        cl = '{4'h0, 4'h0, 4'h1, 4'h0};
        ec = '{4'h0, 4'h0, 4'h1, 4'h0};
        bus_if.irq_en = 4'hE;
        for (int r = 0; r < 4; r++) begin
            bus_if.xfer_done = d[r];
            bus_if.irq_clr   = cl[r];
            exp_q.push_back('{4'h0, ec[r], 1'b0});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL mask[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] d[5], cl[5], ep[5], ec[5];
        logic       ei[5];
        exp_t       e;
        d  = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        cl = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0};
        ep = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
        ec = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0};
        ei = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus_if.irq_en = 4'hF;
        for (int r = 0; r < 5; r++) begin
            bus_if.xfer_done = d[r];
            bus_if.irq_clr   = cl[r];
            exp_q.push_back('{ep[r], ec[r], ei[r]});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL simultaneous[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] d[9], cl[9], ep[9], ec[9];
        logic       ei[9];
        exp_t       e;
        // rows 0-2 build pending=1011; rows 3-8 follow the reset release
        d  = '{4'hB, 4'hB, 4'hB, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        cl = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        ep = '{4'h0, 4'hB, 4'hB, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
        ec = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        ei = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bus_if.irq_en = 4'hF;
        for (int r = 0; r < 9; r++) begin
            if (r == 3) begin
                #2 rst_n = 1'b0;
                bus_if.xfer_done = 4'h1;
                exp_q.push_back('{4'h0, 4'h0, 1'b0});
                #1;
                e = exp_q.pop_front();
                if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                    n_mis++;
                    $display("FAIL async_reset_assert: got p=%b c=%b irq=%b want p=%b c=%b irq=%b",
                             bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
                end
                n_cmp++;
                @(negedge clk);
                rst_n = 1'b1;
            end
            bus_if.xfer_done = d[r];
            bus_if.irq_clr   = cl[r];
            exp_q.push_back('{ep[r], ec[r], ei[r]});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL async_reset[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
    endtask

`ifdef ADMA_IRQ_COAL_EN
    task automatic test_coal_thresh();
        logic [3:0] d[9], cl[9], ep[9], ec[9];
        logic       ei[9];
        exp_t       e;
        d  = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'h0};
        cl = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0};
        ep = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'h0, 4'h0};
        ec = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0};
        ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus_if.irq_en       = 4'hF;
        bus_if.coal_thresh  = 8'd3;
        bus_if.coal_timeout = 8'd0;
        for (int r = 0; r < 9; r++) begin
            bus_if.xfer_done = d[r];
            bus_if.irq_clr   = cl[r];
            exp_q.push_back('{ep[r], ec[r], ei[r]});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL coal_thresh[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
    endtask

    task automatic test_coal_timeout();
        exp_t e;
        bus_if.irq_en       = 4'hF;
        bus_if.coal_thresh  = 8'd8;
        bus_if.coal_timeout = 8'd10;
        // rows 0-14: single event then timeout fire; rows 15-29: cleared in ACCUM
        for (int r = 0; r < 30; r++) begin
            bus_if.xfer_done = (r < 13) ? 4'h8 : ((r >= 15 && r < 18) ? 4'h2 : 4'h0);
            bus_if.irq_clr   = (r == 13) ? 4'h8 : ((r == 17) ? 4'h2 : 4'h0);
            exp_q.push_back('{(r >= 1 && r < 13) ? 4'h8 : ((r == 16) ? 4'h2 : 4'h0),
                              (r == 13) ? 4'h8 : ((r == 17) ? 4'h2 : 4'h0),
                              (r == 12 || r == 13)});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if ({bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq} !== {e.p, e.c, e.i}) begin
                n_mis++;
                $display("FAIL coal_timeout[%0d]: got p=%b c=%b irq=%b want p=%b c=%b irq=%b", r,
                         bus_if.irq_pending, bus_if.xfer_done_clear, bus_if.irq, e.p, e.c, e.i);
            end
            n_cmp++;
        end
        bus_if.coal_thresh  = 8'd1;
        bus_if.coal_timeout = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_hold_clear();
        test_mask();
        test_simultaneous();
        test_async_reset();
`ifdef ADMA_IRQ_COAL_EN
        test_coal_thresh();
        test_coal_timeout();
`endif
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        n_cmp++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
